led_pattern_seq: RTL and testbench

- Parametrised LED pattern sequencer for the board LED bank.
- Drives N_LED LEDs in one of five animation modes.
- Mode is stepped up/down by debounced button pulses; supports pause and a 2-bit speed select.
- Sits between the debounce stage (single-cycle pulse outputs) and the LED pins.

---
 rtl/led_pattern_seq_if.sv | 15 +
 rtl/led_pattern_seq.sv | 99 +++++++++
 tb/tb_led_pattern_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// Control/status bundle between the debounce stage, the LED sequencer and the LED pins.
interface led_pattern_seq_if #(
  parameter int N_LED = 4
) ();
  logic             UP;
  logic             DOWN;
  logic             PAUSE;
  logic [1:0]       SPEED;
  logic [N_LED-1:0] LED;
  logic [2:0]       MODE;
  logic             TICK;

  modport master (output UP, DOWN, PAUSE, SPEED, input LED, MODE, TICK);
  modport slave  (input UP, DOWN, PAUSE, SPEED, output LED, MODE, TICK);
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: five animation modes stepped by a free-running prescaler,
// with mode up/down, pause toggle and 2-bit speed select.
module led_pattern_seq #(
  parameter int N_LED = 4,
  parameter int DIV_W = 23
) (
  input  logic             CLK,
  input  logic             RST,
  led_pattern_seq_if.slave bus
);

  localparam logic [2:0] M_BOUNCE = 3'd0;
  localparam logic [2:0] M_LEFT   = 3'd1;
  localparam logic [2:0] M_RIGHT  = 3'd2;
  localparam logic [2:0] M_COUNT  = 3'd3;
  localparam logic [2:0] M_BLINK  = 3'd4;

  logic [DIV_W-1:0] prescaler;
  logic [DIV_W-1:0] tick_mask;
  logic [N_LED-1:0] step;
  logic [N_LED-1:0] last;
  logic [N_LED-1:0] led;
  logic [2:0]       mode;
  logic [2:0]       mode_nxt;
  logic             paused;
  logic             tick;
  logic             mode_chg;

  // Only the low DIV_W-SPEED prescaler bits take part in the all-ones test.
  assign tick_mask = {DIV_W{1'b1}} >> bus.SPEED;
  assign tick      = &(prescaler | ~tick_mask);
  assign mode_chg  = bus.UP ^ bus.DOWN;

  always_comb begin
    mode_nxt = mode;
    if (bus.UP && !bus.DOWN)
      mode_nxt = (mode >= M_BLINK) ? M_BOUNCE : mode + 3'd1;
    else if (bus.DOWN && !bus.UP) begin
      // Out-of-range modes step down as if they were blink.
      if (mode == M_BOUNCE)     mode_nxt = M_BLINK;
      else if (mode > M_BLINK)  mode_nxt = M_COUNT;
      else                      mode_nxt = mode - 3'd1;
    end
  end

  always_comb begin
    last = '0;
    case (mode)
      M_BOUNCE:        last = N_LED'(2 * N_LED - 3);
      M_LEFT, M_RIGHT: last = N_LED'(N_LED - 1);
      M_COUNT:         last = '1;
      M_BLINK:         last = N_LED'(1);
      default:         last = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler <= '0;
      step      <= '0;
      mode      <= M_BOUNCE;
      paused    <= 1'b0;
    end else begin
      paused <= paused ^ bus.PAUSE;
      if (mode_chg) begin
        mode      <= mode_nxt;
        step      <= '0;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
        if (tick && !paused)
          step <= (step == last) ? '0 : step + 1'b1;
      end
    end
  end

  always_comb begin
    led = '0;
    case (mode)
      M_BOUNCE:
        for (int unsigned i = 0; i < N_LED; i++)
          led[i] = (step == N_LED'(i)) || (step == N_LED'(2 * N_LED - 2 - i));
      M_LEFT:
        for (int unsigned i = 0; i < N_LED; i++)
          led[i] = (step == N_LED'(i));
      M_RIGHT:
        for (int unsigned i = 0; i < N_LED; i++)
          led[i] = (step == N_LED'(N_LED - 1 - i));
      M_COUNT: led = step;
      M_BLINK: led = (step == '0) ? '1 : '0;
      default: led = '0;
    endcase
  end

  assign bus.LED  = led;
  assign bus.MODE = mode;
  assign bus.TICK = tick;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Randomized and directed checks of led_pattern_seq against an integer pattern model.
module tb_led_pattern_seq;

  localparam int N   = 4;
  localparam int DW  = 4;
  localparam int PER = 1 << DW;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: animation position and plain counters.
  int   m_mode, m_step, m_pre;
  bit   m_paused;

  led_pattern_seq_if #(.N_LED(N)) bus ();

  led_pattern_seq #(.N_LED(N), .DIV_W(DW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int seq_len(input int m);
    case (m)
      0:       return 2 * N - 2;
      1, 2:    return N;
      3:       return 1 << N;
      default: return 2;
    endcase
  endfunction

  function automatic logic [N-1:0] exp_led(input int m, input int k);
    case (m)
      0:       return N'(1 << ((k < N) ? k : 2 * N - 2 - k));
      1:       return N'(1 << k);
      2:       return N'(1 << (N - 1 - k));
      3:       return N'(k);
      default: return (k == 0) ? '1 : '0;
    endcase
  endfunction

  function automatic bit exp_tick(input int pre, input logic [1:0] spd);
    int p;
    p = PER >> spd;
    return (pre % p) == p - 1;
  endfunction

  // One clock: apply inputs, advance model at the edge, compare at the next falling edge.
  task automatic cycle(input bit r, input bit u, input bit d, input bit p, input logic [1:0] s);
    bit t;
    rst = r; bus.UP = u; bus.DOWN = d; bus.PAUSE = p; bus.SPEED = s;
    @(posedge clk);
    t = exp_tick(m_pre, s);
    if (r) begin
      m_mode = 0; m_step = 0; m_pre = 0; m_paused = 0;
    end else begin
      if (u != d) begin
        m_mode = u ? ((m_mode + 1) % 5) : ((m_mode + 4) % 5);
        m_step = 0;
        m_pre  = 0;
      end else begin
        m_pre = (m_pre + 1) % PER;
        if (t && !m_paused) m_step = (m_step + 1) % seq_len(m_mode);
      end
      m_paused = m_paused ^ p;
    end
    @(negedge clk);
    check_eq("MODE", 32'(bus.MODE), 32'(m_mode));
    check_eq("LED",  32'(bus.LED),  32'(exp_led(m_mode, m_step)));
    check_eq("TICK", 32'(bus.TICK), 32'(exp_tick(m_pre, bus.SPEED)));
  endtask

  task automatic idle(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, s);
  endtask

  task automatic go_mode(input int target);
    for (int i = 0; i < 5 && m_mode != target; i++) cycle(0, 1, 0, 0, bus.SPEED);
  endtask

  initial begin
    int ticks;
    m_mode = 0; m_step = 0; m_pre = 0; m_paused = 0;
    rst = 1'b1; bus.UP = 0; bus.DOWN = 0; bus.PAUSE = 0; bus.SPEED = 2'd0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0);
    check_eq("reset_led",  32'(bus.LED),  32'h1);
    check_eq("reset_mode", 32'(bus.MODE), 32'h0);
    check_eq("reset_tick", 32'(bus.TICK), 32'h0);

    // Full bounce sweep; exactly one TICK per 16 cycles.
    ticks = 0;
    for (int i = 0; i < 7 * PER; i++) begin
      cycle(0, 0, 0, 0, 0);
      ticks += int'(bus.TICK);
    end
    check_eq("tick_count", 32'(ticks), 32'(7));

    // Wraps at the mode ends and simultaneous UP/DOWN.
    go_mode(4);
    idle(20, 0);
    cycle(0, 1, 0, 0, 0);
    check_eq("up_wrap_mode", 32'(bus.MODE), 32'h0);
    check_eq("up_wrap_led",  32'(bus.LED),  32'h1);
    cycle(0, 0, 1, 0, 0);
    check_eq("down_wrap_mode", 32'(bus.MODE), 32'h4);
    check_eq("down_wrap_led",  32'(bus.LED),  32'hF);
    idle(20, 0);
    cycle(0, 1, 1, 0, 0);

    // Full count wrap at speed 0, then each mode at the fastest speed.
    go_mode(3);
    idle(17 * PER + 3, 0);
    for (int m = 0; m < 5; m++) begin
      go_mode(m);
      idle(40, 3);
    end

    // Speed changes mid-run.
    idle(30, 2);
    idle(40, 0);
    idle(13, 1);

    // Pause at left step 2, mode change while paused, resume.
    go_mode(1);
    idle(2 * PER + 1, 0);
    cycle(0, 0, 0, 1, 0);
    idle(3 * PER, 0);
    check_eq("paused_led", 32'(bus.LED), 32'h4);
    cycle(0, 1, 0, 0, 0);
    check_eq("paused_up_led", 32'(bus.LED), 32'h8);
    idle(2 * PER, 0);
    cycle(0, 0, 0, 1, 0);
    idle(PER, 0);

    // Reset while paused in right mode.
    idle(2 * PER, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("rst_paused_led", 32'(bus.LED), 32'h1);
    idle(2 * PER, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, u, d, p;
      logic [1:0] s;
      r = ($urandom_range(0, 599) == 0);
      u = ($urandom_range(0, 119) == 0);
      d = ($urandom_range(0, 119) == 0);
      p = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 99) == 0) ? 2'($urandom_range(0, 3)) : bus.SPEED;
      cycle(r, u, d, p, s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
